// File: rtl/a_line_acq_pp.sv
// a_line_acq_pp: multi-channel A-line capture into a ping-pong buffer,
// streamed out over a valid/ready port while the next sweep is captured.
// Optional build macro: OFFSET_BIN_EN (invert sample MSB at the write port,
// turning two's complement into offset binary).
//
// Handshake: a beat transfers on a rising clk_system edge when rd_valid and
// rd_ready are both high; while rd_valid=1 and rd_ready=0 every rd_* field is
// held stable, and rd_valid never drops without a transfer.
module a_line_acq_pp #(
  parameter int DATA_W   = 14,
  parameter int NCHAN    = 2,
  parameter int NSAMPLES = 1170,
  parameter int ADDR_W   = 11
) (
  input  logic                    clk_system,
  input  logic                    global_reset,
  input  logic                    trigger50kHz,
  input  logic [NCHAN*DATA_W-1:0] adc_data,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [1:0]              rd_chan,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_last,
  output logic [ADDR_W-1:0]       sample_pos,
  output logic                    acq_busy,
  output logic                    overrun,
  output logic                    short_sweep,
  output logic [15:0]             aline_count,
  output logic [15:0]             drop_count
);

  localparam logic [0:0] C_IDLE   = 1'b0;
  localparam logic [0:0] C_CAPT   = 1'b1;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_STREAM = 1'b1;

  localparam int              WORD_W    = NCHAN * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NSAMPLES - 1);
  localparam logic [1:0]        LAST_CHAN = 2'(NCHAN - 1);

  // One wide word per sample index holds all channels; address = {bank, index}.
  logic [WORD_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  // Capture side
  logic [0:0]        cap_state;
  logic              trig_q;
  logic              wr_bank;
  logic [1:0]        full_q;
  logic              start;
  logic              wr_en;
  logic              commit;
  logic              cap_abort;
  logic              ovr_evt;
  logic [ADDR_W-1:0] wr_idx;
  logic [WORD_W-1:0] wr_word;

  // Read side
  logic [0:0]        rd_state;
  logic              rd_bank;
  logic              iss_done;
  logic [1:0]        cnt_chan;
  logic [ADDR_W-1:0] cnt_idx;
  logic              s1_valid;
  logic              s1_last;
  logic [1:0]        s1_chan;
  logic [ADDR_W-1:0] s1_idx;
  logic [WORD_W-1:0] mem_q;
  logic              adv_out;
  logic              adv_s1;
  logic              issue;
  logic              iss_last;
  logic              rd_done;

  assign acq_busy = (cap_state == C_CAPT);

  // Capture control decode: start edge, write enable, commit and abort.
  always_comb begin
    start     = trigger50kHz & ~trig_q;
    wr_en     = 1'b0;
    wr_idx    = sample_pos;
    commit    = 1'b0;
    cap_abort = 1'b0;
    ovr_evt   = 1'b0;
    if (cap_state == C_IDLE) begin
      wr_idx  = '0;
      wr_en   = start & ~full_q[wr_bank];
      ovr_evt = start & full_q[wr_bank];
    end else if (trigger50kHz) begin
      wr_en  = 1'b1;
      commit = (sample_pos == LAST_IDX);
    end else begin
      cap_abort = 1'b1;
    end
  end

  // Sample formatting at the write port.
  always_comb begin
    wr_word = adc_data;
`ifdef OFFSET_BIN_EN
    for (int c = 0; c < NCHAN; c++) begin
      wr_word[c*DATA_W + DATA_W - 1] = ~adc_data[c*DATA_W + DATA_W - 1];
    end
`endif
  end

  // Buffer write port.
  always_ff @(posedge clk_system) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= wr_word;
  end

  // Capture FSM, counters and registered event pulses.
  always_ff @(posedge clk_system) begin
    if (global_reset) begin
      cap_state   <= C_IDLE;
      trig_q      <= 1'b0;
      wr_bank     <= 1'b0;
      sample_pos  <= '0;
      overrun     <= 1'b0;
      short_sweep <= 1'b0;
      aline_count <= '0;
      drop_count  <= '0;
    end else begin
      trig_q      <= trigger50kHz;
      overrun     <= ovr_evt;
      short_sweep <= cap_abort;
      if ((ovr_evt || cap_abort) && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
      case (cap_state)
        C_IDLE: begin
          // Index 0 is written in the start cycle itself.
          if (wr_en) begin
            cap_state  <= C_CAPT;
            sample_pos <= ADDR_W'(1);
          end
        end
        default: begin
          if (cap_abort) begin
            // Bank stays empty and is reused by the next sweep.
            cap_state  <= C_IDLE;
            sample_pos <= '0;
          end else if (commit) begin
            cap_state   <= C_IDLE;
            sample_pos  <= '0;
            wr_bank     <= ~wr_bank;
            aline_count <= aline_count + 16'd1;
          end else begin
            sample_pos <= sample_pos + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Bank full flags: set on commit, cleared when the last beat is accepted.
  always_ff @(posedge clk_system) begin
    if (global_reset) begin
      full_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wr_bank == 1'(b)))
          full_q[b] <= 1'b1;
        else if (rd_done && (rd_bank == 1'(b)))
          full_q[b] <= 1'b0;
      end
    end
  end

  // Read pipeline decode; in R_IDLE the pipeline is always empty, so the
  // first read can be issued in the same cycle the full flag is seen.
  always_comb begin
    adv_out  = ~rd_valid | rd_ready;
    adv_s1   = ~s1_valid | adv_out;
    rd_done  = rd_valid & rd_ready & rd_last;
    iss_last = (cnt_chan == LAST_CHAN) && (cnt_idx == LAST_IDX);
    if (rd_state == R_IDLE) issue = full_q[rd_bank];
    else                    issue = ~iss_done & adv_s1;
  end

  // Read FSM and issue counters (channel-major beat order).
  always_ff @(posedge clk_system) begin
    if (global_reset) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      cnt_chan <= '0;
      cnt_idx  <= '0;
      iss_done <= 1'b0;
    end else begin
      if (issue) begin
        rd_state <= R_STREAM;
        if (cnt_idx == LAST_IDX) begin
          cnt_idx <= '0;
          if (cnt_chan == LAST_CHAN) iss_done <= 1'b1;
          else                       cnt_chan <= cnt_chan + 2'd1;
        end else begin
          cnt_idx <= cnt_idx + ADDR_W'(1);
        end
      end
      if (rd_done) begin
        rd_state <= R_IDLE;
        rd_bank  <= ~rd_bank;
        cnt_chan <= '0;
        cnt_idx  <= '0;
        iss_done <= 1'b0;
      end
    end
  end

  // Synchronous memory read (stage 1 data).
  always_ff @(posedge clk_system) begin
    if (adv_s1 && issue) mem_q <= mem[{rd_bank, cnt_idx}];
  end

  // Stage 1 tags and registered output stage.
  always_ff @(posedge clk_system) begin
    if (global_reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_chan  <= '0;
      s1_idx   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_chan  <= '0;
      rd_addr  <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (adv_s1) begin
        s1_valid <= issue;
        s1_last  <= iss_last;
        s1_chan  <= cnt_chan;
        s1_idx   <= cnt_idx;
      end
      if (adv_out) begin
        rd_valid <= s1_valid;
        rd_data  <= mem_q[int'(s1_chan)*DATA_W +: DATA_W];
        rd_chan  <= s1_chan;
        rd_addr  <= s1_idx;
        rd_last  <= s1_last & s1_valid;
      end
    end
  end

endmodule

// File: doc/a_line_acq_pp.md
# a_line_acq_pp

Parametrised successor to the single-channel A-line acquisition path. On each rising edge of the sweep trigger, captures `NSAMPLES` consecutive samples from each of `NCHAN` ADC channels into a ping-pong A-line buffer. Streams completed A-lines out over a valid/ready interface while the next sweep is captured. Sits between the ADC capture registers and the downstream processing/transfer logic, all in the ADC clock domain.

## Interface
Parameters:
- `DATA_W`, 14: ADC sample width.
- `NCHAN`, 2: number of ADC channels captured per sweep (1..4).
- `NSAMPLES`, 1170: samples per channel per A-line (2..2047).
- `ADDR_W`, 11: sample index width; must satisfy 2^ADDR_W ≥ NSAMPLES.

Ports:
- `clk_system` in 1: single clock, ADC data-out clock rate. All ports are synchronous to it.
- `global_reset` in 1: synchronous, active-high reset.
- `trigger50kHz` in 1: sweep trigger level, high during the sweep. Already synchronised.
- `adc_data` in NCHAN*DATA_W: packed samples; channel c occupies bits [c*DATA_W +: DATA_W].
- `rd_ready` in 1: downstream accepts the current beat.
- `rd_valid` out 1: `rd_data` is valid.
- `rd_data` out DATA_W: sample word.
- `rd_chan` out 2: channel of the current beat.
- `rd_addr` out ADDR_W: sample index of the current beat.
- `rd_last` out 1: final beat of the A-line.
- `sample_pos` out ADDR_W: current capture index; 0 when not capturing.
- `acq_busy` out 1: capture in progress.
- `overrun` out 1: one-cycle pulse when an A-line is dropped because no bank is free.
- `short_sweep` out 1: one-cycle pulse when the trigger falls before capture completes.
- `aline_count` out 16: committed A-lines, wraps modulo 2^16.
- `drop_count` out 16: overrun plus short-sweep events, saturates at 0xFFFF.

## Operation
- Storage is two banks, each holding NCHAN×NSAMPLES words of DATA_W bits. Each bank carries a full flag.
- Edge detect: a registered copy `trig_q` is kept. The start condition is `trigger50kHz=1 && trig_q=0`.
- Capture FSM has states C_IDLE and C_CAPT.
  - C_IDLE → C_CAPT on a start condition when the write bank is empty. In that same cycle, sample index 0 of every channel is written.
  - A start condition with the write bank full stays in C_IDLE and pulses `overrun`.
  - C_CAPT writes index `sample_pos` of every channel each cycle.
  - After index NSAMPLES-1 is written: set the bank's full flag, toggle the write bank, increment `aline_count`, and go to C_IDLE.
  - If `trigger50kHz`=0 in C_CAPT, nothing is written that cycle. The bank stays empty and is reused, `short_sweep` pulses, and the FSM goes to C_IDLE.
- Read FSM has states R_IDLE and R_STREAM.
  - R_IDLE → R_STREAM when the read bank is full.
  - Beat order: channel 0 indices 0..NSAMPLES-1, then channel 1, and so on.
  - A beat transfers on `rd_valid && rd_ready`. Output fields are held stable while `rd_valid=1` and `rd_ready=0`.
  - On the transfer of the `rd_last` beat: clear the bank's full flag, toggle the read bank, and go to R_IDLE.
- Banks are consumed in commit order, starting with bank 0 after reset.
- `acq_busy` = (capture state is C_CAPT).
- Reset clears all outputs, counters, both full flags and both bank pointers, and returns both FSMs to idle. A capture or stream in progress is discarded without any pulse.

## Timing
- Sample index k of a sweep is taken from `adc_data` in the k-th cycle after the start condition, with the start cycle counted as k=0.
- Full flag is set on the clock edge after the write of index NSAMPLES-1.
- Memory read latency is 1 cycle and the output is registered. The first `rd_valid` of an A-line is therefore asserted 2 cycles after the full flag is set.
- With `rd_ready` held high, throughput is 1 beat/cycle with no gaps, including across channel boundaries.
- Back-to-back A-lines are separated by ≥2 idle cycles on the read side.
- A full-flag set and a full-flag clear in the same cycle on different banks are both honoured. A bank freed in cycle t is writable by a start condition in cycle t+1.
- `overrun` and `short_sweep` are registered. Each pulses exactly one cycle, in the cycle after the causing event.
- `drop_count` updates in the same cycle as the pulse.

## Configuration
- `OFFSET_BIN_EN`:
  - Defined: the MSB of every sample is inverted at the write port, converting two's complement to offset binary, so `rd_data` is offset binary.
  - Undefined: samples are stored and output unmodified.

## Test plan
Bench parameters: NCHAN=2, NSAMPLES=8.

- **Single sweep.** Reset, then raise the trigger for 10 cycles with ch0 = 0x0000+k and ch1 = 0x0100+k. Expect 16 beats: ch0 values 0..7, then ch1 values 0x100..0x107; `rd_last` on beat 16; `aline_count`=1.
- **Backpressure.** Repeat the single sweep with `rd_ready` toggling 1,0,1,0. Expect data identical and held stable during stalls, no beat lost or duplicated.
- **Overrun.** Hold `rd_ready`=0 and issue 3 sweeps. Expect 2 commits, one `overrun` pulse on the third start, `drop_count`=1. Release `rd_ready` → 32 beats from sweeps 1 and 2 in order.
- **Short sweep.** Trigger high for 5 cycles only. Expect `short_sweep` pulse, no `rd_valid`, `drop_count`=1. The next full sweep then streams normally into bank 0.
- **Reset mid-capture.** Assert `global_reset` at `sample_pos`=4. Expect all outputs 0 the next cycle, no `rd_valid`, and the next sweep captures correctly.
- **`OFFSET_BIN_EN` defined.** Input 0x2000 (most negative) → `rd_data`=0x0000; input 0x1FFF → 0x3FFF.
